k_sort: RTL and testbench
=========================

// Module: k_sort
// PURPOSE
//  Streaming top-K selector feeding the k-type voting stage. Consumes N (distance, type)
//  samples per query and keeps a distance-ascending list of the K nearest by one-cycle
//  insertion. It then publishes the K types with a one-cycle valid_sort pulse, and holds
//  them stable for the downstream multi-cycle vote.
// PARAMETERS
//  N       64  samples (training points) per query; N >= K required
//  W       16  distance width, unsigned
//  K       5   neighbours kept; K >= 1
//  TYPE_W  2   class/type label width
// PORTS
//  clk                          in   1          clock
//  rst                          in   1          synchronous, active-high reset
//  start                        in   1          begin new query (honoured only in IDLE)
//  in_valid                     in   1          sample present
//  in_ready                     out  1          sample accepted when in_valid & in_ready
//  in_distance                  in   W          sample distance
//  in_type                      in   TYPE_W     sample type label
//  k_nearest_neighbours_type    out  TYPE_W x K unpacked [0:K-1]; index 0 = nearest
//  valid_sort                   out  1          1-cycle pulse: list published
//  busy                         out  1          high in LOAD and DONE
// BEHAVIOUR
//  Reset: state IDLE, in_ready=0, valid_sort=0, busy=0, all outputs and internal slots 0,
//   slot_valid=0, sample counter 0. Reset mid-query abandons the query and drops partial
//   results; outputs return to 0.
//  FSM:
//   - IDLE: in_ready=0. start=1 -> clear slot_valid and counter, go to LOAD.
//   - LOAD: in_ready=1. Each accept inserts the sample at the next edge.
//     Counter width $clog2(N+1). On the Nth accept -> DONE.
//   - DONE: in_ready=0. Copy slot types to outputs and set valid_sort=1 at the edge
//     leaving DONE -> IDLE.
//  Latency: valid_sort is high in the 2nd cycle after the cycle of the Nth accept,
//   for exactly 1 cycle. Min query = 1 (start) + N + 2 cycles.
//  Insertion, all K slots in parallel:
//   - pos = first i such that !slot_valid[i] or in_distance < dist[i] (strict).
//   - Slots pos..K-2 shift down one; slot K-1 is dropped; the sample is written at pos.
//   - If no such i exists, the sample is discarded.
//   - Ties: the earlier sample keeps the nearer rank.
//   - Distance all-ones is a legal value; emptiness is tracked by slot_valid, never by a
//     sentinel distance.
//  Outputs hold their value from one publish until the next publish or reset;
//   start does not clear them.
//  start outside IDLE is ignored, including start coincident with the DONE cycle.
//  in_valid outside LOAD is ignored; a sample is never consumed.
//  in_valid may drop at any time in LOAD; the counter advances only on accepts.
// CONFIGURATION
//  K_SORT_DIST_OUT_EN defined:
//   - Adds output k_nearest_neighbours_dist, W x K, unpacked [0:K-1].
//   - Published and held with the types on the same edge; reset value 0.
//  Not defined: the port is absent; distances stay internal. Type output timing is
//   identical in both builds.
// TESTING  (N=6, K=3, W=16, TYPE_W=2 unless noted)
//  1. start; dist 50,10,40,20,30,60 / type 0,1,2,3,0,1 back-to-back
//     -> valid_sort 1 cycle, 2 cycles after last accept; types [1,3,0]
//     (dist [10,20,30] with _EN).
//  2. N=4: dist 5,5,5,5 / type 1,2,3,0 -> types [1,2,3] (stable tie order).
//  3. dist 0xFFFF x6 / type 2,1,0,3,3,3 -> types [2,1,0]; no empty-slot leak.
//  4. in_valid toggled 1,0,0,1,... with start pulsed mid-LOAD
//     -> start ignored; exactly 6 accepts; test-1 result; outputs held until next publish.
//  5. rst after 3 accepts -> outputs 0, in_ready 0, no valid_sort; new query then gives
//     the correct result.

Source files
------------

// File: rtl/k_sort.sv
// ============================================================================
// k_sort -- streaming top-K selector
//
// Purpose:
//   Takes N (distance, type) samples for each query and keeps the K nearest
//   in a distance-ascending list. Each accepted sample is inserted in a single
//   cycle, with all K slots updated in parallel. When the N-th sample has been
//   inserted, the K types are copied to the outputs and valid_sort pulses for
//   one cycle. The outputs then hold until the next publish or reset, because
//   the downstream vote takes several cycles to read them.
//
// Parameters:
//   N       samples per query (N >= K)
//   W       distance width, unsigned
//   K       neighbours kept (K >= 1)
//   TYPE_W  class/type label width
//
// Ports:
//   clk                        in   clock
//   rst                        in   synchronous active-high reset
//   start                      in   begin a new query (taken only in IDLE)
//   in_valid                   in   sample present
//   in_ready                   out  high in LOAD; accept = in_valid & in_ready
//   in_distance   [W-1:0]      in   sample distance
//   in_type       [TYPE_W-1:0] in   sample type label
//   k_nearest_neighbours_type  out  [0:K-1] types, index 0 = nearest
//   k_nearest_neighbours_dist  out  [0:K-1] distances (only with the macro)
//   valid_sort                 out  one-cycle pulse when the list is published
//   busy                       out  high in LOAD and DONE
//
// Configuration:
//   K_SORT_DIST_OUT_EN  when defined, adds k_nearest_neighbours_dist. It is
//                       published and held together with the types.
// ============================================================================
module k_sort #(
    parameter int N      = 64,
    parameter int W      = 16,
    parameter int K      = 5,
    parameter int TYPE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_distance,
    input  logic [TYPE_W-1:0] in_type,
    output logic [TYPE_W-1:0] k_nearest_neighbours_type [0:K-1],
`ifdef K_SORT_DIST_OUT_EN
    output logic [W-1:0]      k_nearest_neighbours_dist [0:K-1],
`endif
    output logic              valid_sort,
    output logic              busy
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_count;
    logic [K-1:0]      r_slotValid;
    logic [W-1:0]      r_dist    [0:K-1];
    logic [TYPE_W-1:0] r_type    [0:K-1];
    logic [TYPE_W-1:0] r_outType [0:K-1];
`ifdef K_SORT_DIST_OUT_EN
    logic [W-1:0]      r_outDist [0:K-1];
`endif
    logic              r_validSort;

    logic              w_accept;
    logic [K-1:0]      w_less;
    logic [K-1:0]      w_ins;
    logic [K-1:0]      w_shift;

    assign in_ready   = (r_state == LOAD);
    assign busy       = (r_state == LOAD) || (r_state == DONE);
    assign w_accept   = in_valid && in_ready;
    assign valid_sort = r_validSort;
    assign k_nearest_neighbours_type = r_outType;
`ifdef K_SORT_DIST_OUT_EN
    assign k_nearest_neighbours_dist = r_outDist;
`endif

    // The insertion point is the first slot that is either empty or holds a
    // strictly larger distance. Using a strict compare lets an earlier sample
    // with an equal distance keep the nearer rank. Emptiness comes only from
    // r_slotValid, so an all-ones distance is still a real value. Every slot
    // after the insertion point shifts down by one.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        w_less  = '0;
        w_ins   = '0;
        w_shift = '0;
        for (int i = 0; i < K; i++) begin
            w_less[i]  = !r_slotValid[i] || (in_distance < r_dist[i]);
            w_ins[i]   = w_less[i] && !seen;
            w_shift[i] = seen;
            seen       = seen || w_less[i];
        end
    end

    // Control path: sequencing through IDLE -> LOAD -> DONE, counting accepts,
    // and publishing. start is honoured only in IDLE. It clears slot validity
    // and the counter, but leaves the published outputs untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_validSort <= 1'b0;
            for (int i = 0; i < K; i++) begin
                r_outType[i] <= '0;
`ifdef K_SORT_DIST_OUT_EN
                r_outDist[i] <= '0;
`endif
            end
        end else begin
            r_validSort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == CW'(N - 1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    for (int i = 0; i < K; i++) begin
                        r_outType[i] <= r_type[i];
`ifdef K_SORT_DIST_OUT_EN
                        r_outDist[i] <= r_dist[i];
`endif
                    end
                    r_validSort <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Slot storage: on each accept, slot K-1 falls off the end and the sample
    // is written at the insertion point. A sample that is not nearer than a
    // full list leaves every slot as it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slotValid <= '0;
            for (int i = 0; i < K; i++) begin
                r_dist[i] <= '0;
                r_type[i] <= '0;
            end
        end else if ((r_state == IDLE) && start) begin
            r_slotValid <= '0;
        end else if (w_accept) begin
            for (int i = 1; i < K; i++) begin
                if (w_shift[i]) begin
                    r_dist[i]      <= r_dist[i-1];
                    r_type[i]      <= r_type[i-1];
                    r_slotValid[i] <= r_slotValid[i-1];
                end
            end
            for (int i = 0; i < K; i++) begin
                if (w_ins[i]) begin
                    r_dist[i]      <= in_distance;
                    r_type[i]      <= in_type;
                    r_slotValid[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_k_sort.sv
// ============================================================================
// tb_k_sort -- self-checking bench for k_sort (N=6, K=3, W=16, TYPE_W=2)
//
// Purpose:
//   Drives directed and randomized queries. A queue-based reference keeps
//   every accepted sample of the current query. When a list is published, the
//   reference picks the K nearest by a stable minimum search. A compare
//   process checks all outputs on every falling edge against this reference.
//   Literal expectations from hand-worked cases pin the reference itself.
//
// Ports: none (top-level bench). Honours K_SORT_DIST_OUT_EN when defined.
// ============================================================================
module tb_k_sort;

    localparam int N  = 6;
    localparam int K  = 3;
    localparam int W  = 16;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_distance;
    logic [TW-1:0] in_type;
    logic [TW-1:0] kType [0:K-1];
`ifdef K_SORT_DIST_OUT_EN
    logic [W-1:0]  kDist [0:K-1];
`endif
    logic          valid_sort;
    logic          busy;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // Reference state: phase 0 = idle, 1 = collecting, 2 = finishing.
    int            phase = 0;
    logic [W-1:0]  mqD [$];
    logic [TW-1:0] mqT [$];
    logic [TW-1:0] expTypes [0:K-1];
    logic [W-1:0]  expDist  [0:K-1];
    bit            expPulse = 1'b0;

    logic [W-1:0]  dA [0:N-1];
    logic [TW-1:0] tA [0:N-1];

    always #5 clk = ~clk;

    k_sort #(.N(N), .W(W), .K(K), .TYPE_W(TW)) u_dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_distance               (in_distance),
        .in_type                   (in_type),
        .k_nearest_neighbours_type (kType),
`ifdef K_SORT_DIST_OUT_EN
        .k_nearest_neighbours_dist (kDist),
`endif
        .valid_sort                (valid_sort),
        .busy                      (busy)
    );

    // Single comparison point: steps the counters and reports a mismatch.
    function automatic void cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Stable selection of the K nearest: repeatedly take the smallest remaining
    // distance, so the earliest sample wins ties.
    function automatic void publish();
        bit used [0:N-1];
        for (int j = 0; j < N; j++) used[j] = 1'b0;
        for (int r = 0; r < K; r++) begin
            int best;
            best = -1;
            for (int j = 0; j < mqD.size(); j++) begin
                if (!used[j] && (best < 0 || mqD[j] < mqD[best])) best = j;
            end
            if (best >= 0) begin
                expTypes[r] = mqT[best];
                expDist[r]  = mqD[best];
                used[best]  = 1'b1;
            end
        end
    endfunction

    // Reference reaction to the inputs present at one rising edge.
    function automatic void modelUpdate(input bit r, input bit s, input bit v,
                                        input logic [W-1:0] d, input logic [TW-1:0] t);
        expPulse = 1'b0;
        if (r) begin
            phase = 0;
            mqD.delete();
            mqT.delete();
            for (int i = 0; i < K; i++) begin
                expTypes[i] = '0;
                expDist[i]  = '0;
            end
        end else begin
            case (phase)
                0: if (s) begin
                    phase = 1;
                    mqD.delete();
                    mqT.delete();
                end
                1: if (v) begin
                    mqD.push_back(d);
                    mqT.push_back(t);
                    if (mqD.size() == N) phase = 2;
                end
                default: begin
                    publish();
                    expPulse = 1'b1;
                    phase    = 0;
                end
            endcase
        end
    endfunction

    task automatic applyStimulus(input bit r, input bit s, input bit v,
                                 input logic [W-1:0] d, input logic [TW-1:0] t);
        rst         = r;
        start       = s;
        in_valid    = v;
        in_distance = d;
        in_type     = t;
        @(posedge clk);
        modelUpdate(r, s, v, d, t);
        #1;
    endtask

    task automatic checkOutput();
        cmp("valid_sort", int'(valid_sort), int'(expPulse));
        cmp("in_ready", int'(in_ready), (phase == 1) ? 1 : 0);
        cmp("busy", int'(busy), (phase != 0) ? 1 : 0);
        for (int i = 0; i < K; i++) begin
            cmp($sformatf("type[%0d]", i), int'(kType[i]), int'(expTypes[i]));
`ifdef K_SORT_DIST_OUT_EN
            cmp($sformatf("dist[%0d]", i), int'(kDist[i]), int'(expDist[i]));
`endif
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    // Pins both the reference and the DUT to hand-computed types.
    task automatic checkLiteral(input string name, input int e0, input int e1, input int e2);
        int e [0:2];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int i = 0; i < K; i++) begin
            cmp($sformatf("%s.model[%0d]", name, i), int'(expTypes[i]), e[i]);
            cmp($sformatf("%s.dut[%0d]", name, i), int'(kType[i]), e[i]);
        end
    endtask

    // mode 0: back-to-back, 1: in_valid 1,0,0 repeating, 2: random gaps.
    // Ends just after the finishing cycle, so the publish is visible.
    task automatic runQuery(input int mode, input bit startMid);
        int idx;
        int cyc;
        bit v;
        bit s;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s = startMid && ($urandom_range(0, 2) == 0);
            applyStimulus(1'b0, s, v, dA[idx], tA[idx]);
            if (v) idx++;
            cyc++;
        end
        cmp("queryBound", idx, N);
        // Finishing cycle: start and a stray sample must both be ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0001, 2'd3);
    endtask

    task automatic loadSet(input int d0, input int d1, input int d2, input int d3,
                           input int d4, input int d5, input int t0, input int t1,
                           input int t2, input int t3, input int t4, input int t5);
        dA[0] = W'(d0); dA[1] = W'(d1); dA[2] = W'(d2);
        dA[3] = W'(d3); dA[4] = W'(d4); dA[5] = W'(d5);
        tA[0] = TW'(t0); tA[1] = TW'(t1); tA[2] = TW'(t2);
        tA[3] = TW'(t3); tA[4] = TW'(t4); tA[5] = TW'(t5);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_distance = '0; in_type = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        checkEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        checkLiteral("reset", 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] basic query");
        loadSet(50, 10, 40, 20, 30, 60, 0, 1, 2, 3, 0, 1);
        runQuery(0, 1'b0);
        checkLiteral("basic", 1, 3, 0);
`ifdef K_SORT_DIST_OUT_EN
        cmp("basic.dist0", int'(kDist[0]), 10);
        cmp("basic.dist2", int'(kDist[2]), 30);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] equal distances");
        loadSet(5, 5, 5, 5, 5, 5, 1, 2, 3, 0, 1, 2);
        runQuery(0, 1'b0);
        checkLiteral("ties", 1, 2, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] all-ones distances");
        loadSet(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2, 1, 0, 3, 3, 3);
        runQuery(0, 1'b0);
        checkLiteral("allOnes", 2, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] gapped input with start mid-load");
        loadSet(50, 10, 40, 20, 30, 60, 0, 1, 2, 3, 0, 1);
        runQuery(1, 1'b1);
        checkLiteral("gapped", 1, 3, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkLiteral("held", 1, 3, 0);

        $display("[TB] reset mid-query");
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, W'(i + 1), TW'(i));
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        checkLiteral("midReset", 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        loadSet(50, 10, 40, 20, 30, 60, 0, 1, 2, 3, 0, 1);
        runQuery(0, 1'b0);
        checkLiteral("afterReset", 1, 3, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] randomized queries");
        for (int q = 0; q < 30; q++) begin
            for (int j = 0; j < N; j++) begin
                dA[j] = (q % 2 == 0) ? W'($urandom_range(0, 7)) : W'($urandom());
                tA[j] = TW'($urandom_range(0, 3));
            end
            if (q % 7 == 3) begin
                applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
                for (int i = 0; i < int'($urandom_range(0, N - 1)); i++)
                    applyStimulus(1'b0, 1'b0, 1'b1, dA[i], tA[i]);
                applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
            end
            runQuery(2, 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom()), '0);
        end

        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
